// File: rtl/sqrt_pkg.sv
// Shared types and sizing helpers for the square-root controller.
package sqrt_pkg;

  localparam int SIZE_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    ITER = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic int max_iter(input int size);
    return size / 4 + 1;
  endfunction

endpackage

// File: rtl/sqrt_iter_counter.sv
// Pass counter for the sqrt controller: load, increment, terminal compare.
module sqrt_iter_counter
  import sqrt_pkg::*;
#(
  parameter int MAX_ITER = 9
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic inc,
  output logic at_max
);

  localparam int W = $clog2(MAX_ITER + 1);

  logic [W-1:0] count;
  logic [W-1:0] nxt;

  assign nxt = load ? W'(1) : count + W'(1);

  // Flags the pass that brings the number of load cycles to MAX_ITER.
  assign at_max = (load | inc) && (nxt == W'(MAX_ITER));

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load | inc) begin
      count <= nxt;
    end
  end

endmodule

// File: rtl/sqrt_controller.sv
// Sequencing FSM and result registers for an iterative integer square root.
module sqrt_controller
  import sqrt_pkg::*;
#(
  parameter int SIZE     = SIZE_DEF,
  parameter int MAX_ITER = max_iter(SIZE)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [SIZE-1:0] num_in,
  output logic            ready,
  output logic            busy,
  output logic            done,
  output logic [SIZE-1:0] result_out,
  output logic            err,
  output logic [SIZE-1:0] dp_num0,
  output logic            dp_mux_select,
  output logic            dp_ld,
  input  logic            dp_finished,
  input  logic [SIZE-1:0] dp_res
);

  state_t          state;
  state_t          nxt;
  logic [SIZE-1:0] opnd;
  logic            zero_f;
  logic            wd_f;
  logic            ld;
  logic            cnt_load;
  logic            cnt_inc;
  logic            at_max;
  logic            accept;
  logic            wd_hit;

  sqrt_iter_counter #(
    .MAX_ITER(MAX_ITER)
  ) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .load  (cnt_load),
    .inc   (cnt_inc),
    .at_max(at_max)
  );

  always_comb begin
    nxt           = state;
    ld            = 1'b0;
    dp_mux_select = 1'b0;
    cnt_load      = 1'b0;
    cnt_inc       = 1'b0;
    accept        = 1'b0;
    wd_hit        = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          accept = 1'b1;
          nxt    = (num_in == '0) ? DONE : LOAD;
        end
      end
      LOAD, ITER: begin
        ld            = 1'b1;
        dp_mux_select = (state == LOAD);
        cnt_load      = (state == LOAD);
        cnt_inc       = (state == ITER);
        if (dp_finished) begin
          nxt = DONE;
        end else if (at_max) begin
          nxt    = DONE;
          wd_hit = 1'b1;
        end else begin
          nxt = ITER;
        end
      end
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Load enable is masked so the datapath never updates under reset.
  assign dp_ld   = ld & ~rst;
  assign ready   = (state == IDLE);
  assign busy    = (state != IDLE);
  assign dp_num0 = opnd;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      opnd       <= '0;
      zero_f     <= 1'b0;
      wd_f       <= 1'b0;
      result_out <= '0;
      err        <= 1'b0;
      done       <= 1'b0;
    end else begin
      state <= nxt;
      done  <= (state == DONE);
      if (accept) begin
        opnd   <= num_in;
        zero_f <= (num_in == '0);
        wd_f   <= 1'b0;
      end
      if (wd_hit) begin
        wd_f <= 1'b1;
      end
      if (state == DONE) begin
        result_out <= (zero_f | wd_f) ? '0 : dp_res;
        err        <= wd_f;
      end
    end
  end

endmodule
